// File: rtl/seg7_pkg.sv
// Shared types, glyph codes and the glyph-to-segment table for the
// seven-segment scan driver. Segment vectors are logical (1 = lit),
// ordered {a,b,c,d,e,f,g} with a as the MSB.
package seg7_pkg;

  typedef logic [4:0] glyph_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_t;

  localparam glyph_t GLYPH_0     = 5'd0;
  localparam glyph_t GLYPH_1     = 5'd1;
  localparam glyph_t GLYPH_2     = 5'd2;
  localparam glyph_t GLYPH_3     = 5'd3;
  localparam glyph_t GLYPH_4     = 5'd4;
  localparam glyph_t GLYPH_5     = 5'd5;
  localparam glyph_t GLYPH_6     = 5'd6;
  localparam glyph_t GLYPH_7     = 5'd7;
  localparam glyph_t GLYPH_8     = 5'd8;
  localparam glyph_t GLYPH_9     = 5'd9;
  localparam glyph_t GLYPH_A     = 5'd10;
  localparam glyph_t GLYPH_B     = 5'd11;
  localparam glyph_t GLYPH_C     = 5'd12;
  localparam glyph_t GLYPH_D     = 5'd13;
  localparam glyph_t GLYPH_E     = 5'd14;
  localparam glyph_t GLYPH_F     = 5'd15;
  localparam glyph_t GLYPH_EQ    = 5'd16;
  localparam glyph_t GLYPH_DASH  = 5'd17;
  localparam glyph_t GLYPH_UNDER = 5'd18;
  localparam glyph_t GLYPH_BLANK = 5'd31;

  // Codes 19..31 all decode to a dark digit.
  function automatic seg_t glyph_to_seg(input glyph_t g);
    seg_t s;
    case (g)
      GLYPH_0:     s = 7'b1111110;
      GLYPH_1:     s = 7'b0110000;
      GLYPH_2:     s = 7'b1101101;
      GLYPH_3:     s = 7'b1111001;
      GLYPH_4:     s = 7'b0110011;
      GLYPH_5:     s = 7'b1011011;
      GLYPH_6:     s = 7'b1011111;
      GLYPH_7:     s = 7'b1110000;
      GLYPH_8:     s = 7'b1111111;
      GLYPH_9:     s = 7'b1111011;
      GLYPH_A:     s = 7'b1111101;
      GLYPH_B:     s = 7'b0011111;
      GLYPH_C:     s = 7'b0001101;
      GLYPH_D:     s = 7'b0111101;
      GLYPH_E:     s = 7'b1101111;
      GLYPH_F:     s = 7'b1000111;
      GLYPH_EQ:    s = 7'b0001001;
      GLYPH_DASH:  s = 7'b0000001;
      GLYPH_UNDER: s = 7'b0001000;
      default:     s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph decoder: 5-bit glyph code to logical segment pattern.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  glyph_t glyph,
  output seg_t   seg
);

  assign seg = glyph_to_seg(glyph);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. A pending frame captured by load
// is promoted to the active frame only at a frame boundary, so a scan never
// mixes two frames. Each digit is lit for SCAN_DIV cycles followed by a
// GUARD_CYC dark gap. All internal logic is active-high; pin polarity is
// applied only when the output registers are loaded.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD_CYC   = 64,
  parameter int SEG_ACT_LO  = 1,
  parameter int AN_ACT_LO   = 1,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [5*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ?
                           ((SCAN_DIV > 2) ? SCAN_DIV : 2) :
                           ((GUARD_CYC > 2) ? GUARD_CYC : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam seg_t                  SEG_OFF = (SEG_ACT_LO != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACT_LO != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LO != 0) ? '1 : '0;

  // Frame buffers
  glyph_t                code_pend_reg [NUM_DIGITS];
  glyph_t                code_act_reg  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_pend_reg, dp_act_reg;
  logic [NUM_DIGITS-1:0] blank_pend_reg, blank_act_reg;
  logic                  pend_valid_reg;

  // Scan FSM
  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next, idx_inc;
  logic             slot_end, frame_end, commit;

  // Decode and output stage
  logic [NUM_DIGITS-1:0] lz_mask, an_onehot, an_logic;
  logic                  zero_run;
  glyph_t                glyph_sel;
  seg_t                  rom_seg, seg_logic;
  logic                  dp_logic;

  seg_t                  seg_reg;
  logic                  dp_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic                  frame_done_reg;

  assign frame_end = slot_end && (idx_reg == IDX_LAST);
  assign commit    = frame_end && pend_valid_reg;

  // Capture into pending on load; promote pending to active at a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        code_pend_reg[i] <= GLYPH_BLANK;
        code_act_reg[i]  <= GLYPH_BLANK;
      end
      dp_pend_reg    <= '0;
      dp_act_reg     <= '0;
      blank_pend_reg <= '0;
      blank_act_reg  <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          code_act_reg[i] <= code_pend_reg[i];
        end
        dp_act_reg    <= dp_pend_reg;
        blank_act_reg <= blank_pend_reg;
      end
      // A load coinciding with the boundary stays pending for the next frame.
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          code_pend_reg[i] <= digits[5*i +: 5];
        end
        dp_pend_reg    <= dp_in;
        blank_pend_reg <= blank_in;
        pend_valid_reg <= 1'b1;
      end else if (commit) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  // FSM state register; reset parks in GUARD on the last digit so digit 0 lights first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_GUARD;
      cnt_reg   <= '0;
      idx_reg   <= IDX_LAST;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  assign idx_inc = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

  // FSM next-state: SHOW for SCAN_DIV cycles, then GUARD (skipped when GUARD_CYC is 0)
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    slot_end   = 1'b0;
    case (state_reg)
      ST_SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          cnt_next = '0;
          slot_end = 1'b1;
          if (GUARD_CYC == 0) begin
            idx_next = idx_inc;
          end else begin
            state_next = ST_GUARD;
          end
        end
      end
      default: begin
        if (cnt_reg == GUARD_LAST) begin
          cnt_next   = '0;
          state_next = ST_SHOW;
          idx_next   = idx_inc;
        end
      end
    endcase
  end

  // Leading-zero mask: a digit is suppressed while every digit from it upward is a plain 0
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (code_act_reg[i] == GLYPH_0) && !dp_act_reg[i];
      lz_mask[i] = (LZ_SUPPRESS != 0) && (i > 0) && zero_run;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
  end

  assign glyph_sel = code_act_reg[idx_reg];

  seg7_glyph_rom u_rom (
    .glyph (glyph_sel),
    .seg   (rom_seg)
  );

  // FSM outputs (logical levels): anode stays driven for blanked/suppressed digits
  always_comb begin
    seg_logic = '0;
    dp_logic  = 1'b0;
    an_logic  = '0;
    if (state_reg == ST_SHOW) begin
      an_logic = an_onehot;
      if (!blank_act_reg[idx_reg] && !lz_mask[idx_reg]) begin
        seg_logic = rom_seg;
        dp_logic  = dp_act_reg[idx_reg];
      end
    end
  end

  // Output registers with pin polarity applied
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_reg        <= SEG_OFF;
      dp_reg         <= DP_OFF;
      an_reg         <= AN_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= (SEG_ACT_LO != 0) ? ~seg_logic : seg_logic;
      dp_reg         <= (SEG_ACT_LO != 0) ? ~dp_logic : dp_logic;
      an_reg         <= (AN_ACT_LO != 0) ? ~an_logic : an_logic;
      frame_done_reg <= frame_end;
    end
  end

  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots and a
// 2-cycle guard. Three instances share the inputs: active-low with and
// without leading-zero suppression, and an active-high one.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [19:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  logic [6:0] seg0, seg1, segh;
  logic       dp0, dp1, dph;
  logic [3:0] an0, an1, anh;
  logic       fd0, fd1, fdh;

  int checks = 0;
  int failures = 0;

  logic [6:0] c_seg0 [4];
  logic [6:0] c_seg1 [4];
  logic [6:0] c_segh [4];
  logic [3:0] c_an0  [4];
  logic [3:0] c_an1  [4];
  logic [3:0] c_anh  [4];
  logic       c_dp0  [4];
  logic       c_dp1  [4];
  logic       c_dph  [4];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(2),
                     .SEG_ACT_LO(1), .AN_ACT_LO(1), .LZ_SUPPRESS(0)) u_lz0 (
    .clk(clk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(2),
                     .SEG_ACT_LO(1), .AN_ACT_LO(1), .LZ_SUPPRESS(1)) u_lz1 (
    .clk(clk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(2),
                     .SEG_ACT_LO(0), .AN_ACT_LO(0), .LZ_SUPPRESS(0)) u_hi (
    .clk(clk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
    .blank_in(blank_in), .seg(segh), .dp(dph), .an(anh), .frame_done(fdh));

  // Called at a negedge; load is seen by exactly one posedge.
  task automatic do_load(input logic [19:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    digits   = d;
    dp_in    = dpv;
    blank_in = bl;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_fd();
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (fd0 !== 1'b1 && waited < 100);
    checks++;
    if (fd0 !== 1'b1) begin
      failures++;
      $display("FAIL wait_frame_done: frame_done=%b after %0d cycles, required 1 within 100", fd0, waited);
    end
  endtask

  // Called at the negedge showing frame_done; samples the first lit cycle of each digit.
  task automatic capture_frame();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (6) @(negedge clk);
      c_seg0[k] = seg0; c_seg1[k] = seg1; c_segh[k] = segh;
      c_an0[k]  = an0;  c_an1[k]  = an1;  c_anh[k]  = anh;
      c_dp0[k]  = dp0;  c_dp1[k]  = dp1;  c_dph[k]  = dph;
    end
    $display("frame digits=%h seg0 d0..d3: %b %b %b %b", digits, c_seg0[0], c_seg0[1], c_seg0[2], c_seg0[3]);
  endtask

  task automatic test_reset();
    logic [3:0] an_exp;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (an0 !== 4'b1111 || seg0 !== 7'h7F || dp0 !== 1'b1 || fd0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_lo: an=%b seg=%b dp=%b fd=%b, required 1111 1111111 1 0", an0, seg0, dp0, fd0);
      end
      checks++;
      if (anh !== 4'b0000 || segh !== 7'h00 || dph !== 1'b0 || fdh !== 1'b0) begin
        failures++;
        $display("FAIL reset_hi: an=%b seg=%b dp=%b fd=%b, required 0000 0000000 0 0", anh, segh, dph, fdh);
      end
    end
    // A load while reset is held must be dropped.
    digits = {5'd8, 5'd8, 5'd8, 5'd8};
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    reset  = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      an_exp = ((c >= 3) && (((c - 3) % 6) < 4)) ? ~(4'b0001 << (((c - 3) / 6) % 4)) : 4'b1111;
      checks++;
      if (an0 !== an_exp) begin
        failures++;
        $display("FAIL powerup_an cycle %0d: an=%b, required %b", c, an0, an_exp);
      end
      checks++;
      if (anh !== ~an_exp) begin
        failures++;
        $display("FAIL powerup_an_hi cycle %0d: an=%b, required %b", c, anh, ~an_exp);
      end
      checks++;
      if (seg0 !== 7'h7F || segh !== 7'h00) begin
        failures++;
        $display("FAIL powerup_seg cycle %0d: seg_lo=%b seg_hi=%b, required 1111111 0000000", c, seg0, segh);
      end
      checks++;
      if (fd0 !== ((c == 24) || (c == 48))) begin
        failures++;
        $display("FAIL powerup_frame_done cycle %0d: fd=%b, required %b", c, fd0, (c == 24) || (c == 48));
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_load_basic();
    logic [6:0] e [4];
    logic [3:0] oh;
    e = '{7'b1110000, 7'b1111101, 7'b1111110, 7'b1111001};
    do_load({5'd3, 5'd0, 5'd10, 5'd7}, 4'b0000, 4'b0000);
    wait_fd();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      checks++;
      if (c_seg0[k] !== ~e[k] || c_seg1[k] !== ~e[k]) begin
        failures++;
        $display("FAIL load_basic_seg d%0d: lz0=%b lz1=%b, required %b", k, c_seg0[k], c_seg1[k], ~e[k]);
      end
      checks++;
      if (c_segh[k] !== e[k]) begin
        failures++;
        $display("FAIL load_basic_seg_hi d%0d: seg=%b, required %b", k, c_segh[k], e[k]);
      end
      checks++;
      if (c_an0[k] !== ~oh || c_anh[k] !== oh) begin
        failures++;
        $display("FAIL load_basic_an d%0d: lo=%b hi=%b, required %b %b", k, c_an0[k], c_anh[k], ~oh, oh);
      end
      checks++;
      if (c_dp0[k] !== 1'b1 || c_dph[k] !== 1'b0) begin
        failures++;
        $display("FAIL load_basic_dp d%0d: lo=%b hi=%b, required 1 0", k, c_dp0[k], c_dph[k]);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] e1 [4];
    logic [6:0] e0 [4];
    logic       dpe [4];
    e1  = '{7'b1011011, 7'b1111110, 7'b1111110, 7'b0000000};
    e0  = '{7'b1011011, 7'b1111110, 7'b1111110, 7'b1111110};
    dpe = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_load({5'd0, 5'd0, 5'd0, 5'd5}, 4'b0100, 4'b0000);
    wait_fd();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_seg1[k] !== ~e1[k]) begin
        failures++;
        $display("FAIL lz_seg d%0d: seg=%b, required %b", k, c_seg1[k], ~e1[k]);
      end
      checks++;
      if (c_seg0[k] !== ~e0[k]) begin
        failures++;
        $display("FAIL lz_off_seg d%0d: seg=%b, required %b", k, c_seg0[k], ~e0[k]);
      end
      checks++;
      if (c_dp1[k] !== ~dpe[k] || c_dph[k] !== dpe[k]) begin
        failures++;
        $display("FAIL lz_dp d%0d: lo=%b hi=%b, required %b %b", k, c_dp1[k], c_dph[k], ~dpe[k], dpe[k]);
      end
      checks++;
      if (c_an1[k] !== ~(4'b0001 << k)) begin
        failures++;
        $display("FAIL lz_an d%0d: an=%b, required %b", k, c_an1[k], ~(4'b0001 << k));
      end
    end
  endtask

  task automatic test_codes();
    logic [19:0] pat [3];
    logic [6:0]  e   [3][4];
    pat = '{{5'd8, 5'd25, 5'd17, 5'd16}, {5'd14, 5'd13, 5'd12, 5'd11}, {5'd19, 5'd6, 5'd18, 5'd15}};
    e[0] = '{7'b0001001, 7'b0000001, 7'b0000000, 7'b1111111};
    e[1] = '{7'b0011111, 7'b0001101, 7'b0111101, 7'b1101111};
    e[2] = '{7'b1000111, 7'b0001000, 7'b1011111, 7'b0000000};
    for (int p = 0; p < 3; p++) begin
      do_load(pat[p], 4'b0000, 4'b0000);
      wait_fd();
      capture_frame();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (c_seg0[k] !== ~e[p][k] || c_segh[k] !== e[p][k]) begin
          failures++;
          $display("FAIL codes_seg pattern %0d d%0d: lo=%b hi=%b, required %b %b", p, k, c_seg0[k], c_segh[k], ~e[p][k], e[p][k]);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] e [4];
    e = '{7'b0110011, 7'b0000000, 7'b1111001, 7'b0110000};
    do_load({5'd1, 5'd3, 5'd2, 5'd4}, 4'b0010, 4'b0010);
    wait_fd();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_seg0[k] !== ~e[k]) begin
        failures++;
        $display("FAIL blank_seg d%0d: seg=%b, required %b", k, c_seg0[k], ~e[k]);
      end
      checks++;
      if (c_dp0[k] !== 1'b1 || c_an0[k] !== ~(4'b0001 << k)) begin
        failures++;
        $display("FAIL blank_dp_an d%0d: dp=%b an=%b, required 1 %b", k, c_dp0[k], c_an0[k], ~(4'b0001 << k));
      end
    end
  endtask

  task automatic test_mid_frame();
    wait_fd();
    repeat (9) @(negedge clk);
    do_load({5'd9, 5'd9, 5'd9, 5'd9}, 4'b0000, 4'b0000);
    repeat (5) @(negedge clk);
    checks++;
    if (seg0 !== 7'b0000110 || an0 !== 4'b1011) begin
      failures++;
      $display("FAIL mid_frame_old_d2: seg=%b an=%b, required 0000110 1011", seg0, an0);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (seg0 !== 7'b1001111 || an0 !== 4'b0111) begin
      failures++;
      $display("FAIL mid_frame_old_d3: seg=%b an=%b, required 1001111 0111", seg0, an0);
    end
    wait_fd();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_seg0[k] !== 7'b0000100) begin
        failures++;
        $display("FAIL mid_frame_new d%0d: seg=%b, required 0000100", k, c_seg0[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_fd();
    repeat (2) @(negedge clk);
    do_load({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 4'b0000);
    repeat (20) @(negedge clk);
    // Hold load across the boundary edge.
    digits = {5'd2, 5'd2, 5'd2, 5'd2};
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    checks++;
    if (fd0 !== 1'b1) begin
      failures++;
      $display("FAIL boundary_align: frame_done=%b, required 1", fd0);
    end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_seg0[k] !== 7'b1001111) begin
        failures++;
        $display("FAIL boundary_first d%0d: seg=%b, required 1001111", k, c_seg0[k]);
      end
    end
    wait_fd();
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_seg0[k] !== 7'b0010010) begin
        failures++;
        $display("FAIL boundary_second d%0d: seg=%b, required 0010010", k, c_seg0[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] an_exp;
    wait_fd();
    repeat (2) @(negedge clk);
    do_load({5'd6, 5'd6, 5'd6, 5'd6}, 4'b0000, 4'b0000);
    @(negedge clk);
    checks++;
    if (an0 !== 4'b1110) begin
      failures++;
      $display("FAIL reset_mid_pre: an=%b, required 1110", an0);
    end
    reset  = 1'b1;
    digits = {5'd8, 5'd8, 5'd8, 5'd8};
    load   = 1'b1;
    @(negedge clk);
    checks++;
    if (an0 !== 4'b1111 || seg0 !== 7'h7F || dp0 !== 1'b1 || fd0 !== 1'b0 || anh !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_outputs: an=%b seg=%b dp=%b fd=%b an_hi=%b, required 1111 1111111 1 0 0000", an0, seg0, dp0, fd0, anh);
    end
    load  = 1'b0;
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      an_exp = ((c >= 3) && (((c - 3) % 6) < 4)) ? ~(4'b0001 << (((c - 3) / 6) % 4)) : 4'b1111;
      checks++;
      if (an0 !== an_exp || seg0 !== 7'h7F) begin
        failures++;
        $display("FAIL reset_mid_restart cycle %0d: an=%b seg=%b, required %b 1111111", c, an0, seg0, an_exp);
      end
      checks++;
      if (fd0 !== (c == 24)) begin
        failures++;
        $display("FAIL reset_mid_frame_done cycle %0d: fd=%b, required %b", c, fd0, c == 24);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_lz();
    test_codes();
    test_blank();
    test_mid_frame();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
